// File: rtl/assert_monitor_pkg.sv
// Shared types and helpers for the multi-channel protocol checker.
package assert_monitor_pkg;

   typedef enum logic {
      KIND_INV = 1'b0,
      KIND_TMO = 1'b1
   } err_kind_e;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } live_state_e;

   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/assert_monitor_live.sv
// One request/acknowledge liveness window with its cycle counter.
module assert_monitor_live
   import assert_monitor_pkg::*;
#(
   parameter int TMO_W = 8
)(
   input  logic             clock,
   input  logic             reset_n,
   input  logic             live_req,
   input  logic             live_ack,
   input  logic [TMO_W-1:0] tmo_limit,
   output logic             tmo_v
);

   live_state_e      r_state;
   logic [TMO_W-1:0] r_cnt;
   logic             w_lim_zero;
   logic             w_hit;

   assign w_lim_zero = (tmo_limit == '0);

   // The ack on the expiry edge still wins, so the check waits on it.
   assign w_hit = (r_state == WAIT) & ~live_ack & ~w_lim_zero
                & (r_cnt == tmo_limit);

   assign tmo_v = w_hit;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (live_req && !w_lim_zero) begin
                  r_state <= WAIT;
                  r_cnt   <= TMO_W'(1);
               end
            end
            WAIT: begin
               if (live_ack || w_lim_zero || w_hit) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + TMO_W'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/assert_monitor.sv
// Multi-channel invariant and liveness checker with sticky, first-failure
// and saturating-count logging plus a registered interrupt.
module assert_monitor
   import assert_monitor_pkg::*;
#(
   parameter int CH    = 4,
   parameter int TERMS = 3,
   parameter int TMO_W = 8,
   parameter int CNT_W = 8,
   parameter bit FATAL = 1'b1
)(
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [CH-1:0]         chk_en,
   input  logic [CH*TERMS-1:0]   terms,
   input  logic [CH-1:0]         live_req,
   input  logic [CH-1:0]         live_ack,
   input  logic [TMO_W-1:0]      tmo_limit,
   input  logic                  clear,
   output logic [CH-1:0]         err_sticky,
   output logic                  err_first_vld,
   output logic [ch_w(CH)-1:0]   err_first_ch,
   output logic                  err_first_kind,
   output logic [CNT_W-1:0]      err_cnt,
   output logic                  irq
);

   localparam int CHW = ch_w(CH);

   logic [CH-1:0]    w_inv;
   logic [CH-1:0]    w_tmo;
   logic [CH-1:0]    w_v;
   logic             w_any;
   logic             w_cnt_full;
   logic [CHW-1:0]   w_sel_ch;
   err_kind_e        w_sel_kind;

   logic [CH-1:0]    r_sticky;
   logic             r_first_vld;
   logic [CHW-1:0]   r_first_ch;
   err_kind_e        r_first_kind;
   logic [CNT_W-1:0] r_cnt;
   logic             r_irq;

   always_comb begin
      w_inv = '0;
      for (int c = 0; c < CH; c++) begin
         w_inv[c] = chk_en[c] & ~(|terms[c*TERMS +: TERMS]);
      end
   end

   for (genvar g = 0; g < CH; g++) begin : g_live
      assert_monitor_live #(
         .TMO_W     (TMO_W)
      ) u_live (
         .clock     (clock),
         .reset_n   (reset_n),
         .live_req  (live_req[g]),
         .live_ack  (live_ack[g]),
         .tmo_limit (tmo_limit),
         .tmo_v     (w_tmo[g])
      );
   end

   assign w_v        = w_inv | w_tmo;
   assign w_any      = |w_v;
   assign w_cnt_full = &r_cnt;

   // Scan downwards so the lowest violating channel is the one kept.
   always_comb begin
      w_sel_ch   = '0;
      w_sel_kind = KIND_INV;
      for (int c = CH - 1; c >= 0; c--) begin
         if (w_v[c]) begin
            w_sel_ch   = CHW'(c);
            w_sel_kind = w_inv[c] ? KIND_INV : KIND_TMO;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sticky     <= '0;
         r_first_vld  <= 1'b0;
         r_first_ch   <= '0;
         r_first_kind <= KIND_INV;
         r_cnt        <= '0;
         r_irq        <= 1'b0;
      end else begin
         r_irq <= |r_sticky;
         if (clear) begin
            r_sticky     <= '0;
            r_first_vld  <= 1'b0;
            r_first_ch   <= '0;
            r_first_kind <= KIND_INV;
            r_cnt        <= '0;
         end else begin
            r_sticky <= r_sticky | w_v;
            if (w_any && !w_cnt_full) begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_any && !r_first_vld) begin
               r_first_vld  <= 1'b1;
               r_first_ch   <= w_sel_ch;
               r_first_kind <= w_sel_kind;
            end
         end
      end
   end

   assign err_sticky     = r_sticky;
   assign err_first_vld  = r_first_vld;
   assign err_first_ch   = r_first_ch;
   assign err_first_kind = r_first_kind;
   assign err_cnt        = r_cnt;
   assign irq            = r_irq;

`ifndef SYNTHESIS
   logic w_printf;
   assign w_printf = 1'b1;
   logic w_stop;
   assign w_stop = 1'b1;

   always @(posedge clock) begin
      if (reset_n) begin
         for (int c = 0; c < CH; c++) begin
            if (w_printf && w_inv[c])
               $display("assert_monitor %m: ch %0d invariant violation at %0t",
                        c, $time);
            if (w_printf && w_tmo[c])
               $display("assert_monitor %m: ch %0d liveness timeout at %0t",
                        c, $time);
         end
         if (FATAL && w_stop && w_any)
            $fatal(1, "assert_monitor %m: stopping on violation");
      end
   end
`endif

endmodule
